// File: rtl/hilo_acc.sv
// HI/LO accumulator: one-entry operand stage followed by a commit stage
// that updates the architectural HI:LO pair and a sticky overflow flag.
module hilo_acc #(
    parameter bit ACC_SAT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [63:0] prod,
    input  logic [31:0] rs,
    input  logic        hold,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        ovf
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_MADD = 3'b010;
    localparam logic [2:0] OP_MSUB = 3'b011;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

    logic        s1_valid;
    logic [2:0]  s1_op;
    logic [63:0] s1_prod;
    logic [31:0] s1_rs;

    logic [63:0] acc;
    logic [63:0] acc_nxt;
    logic        ovf_nxt;
    logic        accept;
    logic        commit;
    logic        is_sub;
    logic [63:0] sum;
    logic        sum_ovf;

    assign in_ready = ~hold | ~s1_valid;
    assign accept   = in_valid & in_ready;
    assign commit   = s1_valid & ~hold;
    assign hi       = acc[63:32];
    assign lo       = acc[31:0];

    // Overflow: add needs equal signs, sub needs differing signs,
    // and in both cases the result sign must leave the accumulator's.
    assign is_sub  = (s1_op == OP_MSUB);
    assign sum     = is_sub ? acc - s1_prod : acc + s1_prod;
    assign sum_ovf = ((acc[63] ^ s1_prod[63]) == is_sub)
                   & (sum[63] ^ acc[63]);

    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf;
        unique case (s1_op)
            OP_LOAD: acc_nxt = s1_prod;
            OP_MADD, OP_MSUB: begin
                if (sum_ovf) begin
                    ovf_nxt = 1'b1;
                    if (ACC_SAT)
                        acc_nxt = acc[63] ? SAT_NEG : SAT_POS;
                    else
                        acc_nxt = sum;
                end else begin
                    acc_nxt = sum;
                end
            end
            OP_MTHI: acc_nxt[63:32] = s1_rs;
            OP_MTLO: acc_nxt[31:0]  = s1_rs;
            OP_CLR: begin
                acc_nxt = '0;
                ovf_nxt = 1'b0;
            end
            OP_NOP, OP_RSVD: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_prod  <= '0;
            s1_rs    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_prod  <= prod;
            s1_rs    <= rs;
        end else if (commit) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= commit & (s1_op != OP_NOP) & (s1_op != OP_RSVD);
            if (commit) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
            end
        end
    end

endmodule
